// File: rtl/systolic_feeder.sv
// Source-side scheduler for an N x N systolic array: buffers A by rows and B by columns, then injects them with diagonal skew.
// Optional SYSTOLIC_FEEDER_DBUF_EN adds a second bank so the next matrix pair loads while the current one is fed.
module systolic_feeder #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic signed [N*DIN_WIDTH-1:0] ld_a_row,
  input  logic signed [N*DIN_WIDTH-1:0] ld_b_col,
  input  logic                          abort,
  output logic signed [N*DIN_WIDTH-1:0] a_din,
  output logic signed [N*DIN_WIDTH-1:0] b_din,
  output logic                          in_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int W  = DIN_WIDTH;
  localparam int TW = $clog2(2*N-1);
  localparam int IW = $clog2(N);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {S_LOAD, S_FEED, S_DONE} state_t;

  state_t                r_state;
  logic [TW-1:0]         r_t;
  logic [IW-1:0]         r_cnt;
  logic signed [W-1:0]   r_a [NB][N][N];
  logic signed [W-1:0]   r_b [NB][N][N];

  logic                  w_acc;
  logic                  w_last;
  logic                  w_wbank;
  logic                  w_sbank;
  logic [TW-1:0]         w_tn;
  logic signed [N*W-1:0] w_a_nxt;
  logic signed [N*W-1:0] w_b_nxt;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic r_full;
  logic r_wr_bank;
  logic r_rd_bank;

  assign ld_ready = (r_state == S_LOAD) || !r_full;
  assign w_wbank  = r_wr_bank;
  // A new feed always starts from the bank that was just filled.
  assign w_sbank  = (r_state == S_FEED) ? r_rd_bank : r_wr_bank;
`else
  assign ld_ready = (r_state == S_LOAD);
  assign w_wbank  = 1'b0;
  assign w_sbank  = 1'b0;
`endif

  assign w_acc  = ld_valid && ld_ready && !abort;
  assign w_last = (r_cnt == IW'(N-1));
  assign w_tn   = (r_state == S_FEED) ? r_t + 1'b1 : '0;

  // Outputs are registered, so the skew is computed for the step about to be shown.
  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(w_tn) >= i && int'(w_tn) < i + N) begin
        w_a_nxt[i*W +: W] = r_a[w_sbank][i][IW'(int'(w_tn) - i)];
        w_b_nxt[i*W +: W] = r_b[w_sbank][IW'(int'(w_tn) - i)][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int k = 0; k < N; k++) begin
        r_a[w_wbank][r_cnt][k] <= $signed(ld_a_row[k*W +: W]);
        r_b[w_wbank][k][r_cnt] <= $signed(ld_b_col[k*W +: W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_LOAD;
      r_t      <= '0;
      r_cnt    <= '0;
      in_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_din    <= '0;
      b_din    <= '0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      r_full    <= 1'b0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
`endif
    end else if (abort) begin
      r_state  <= S_LOAD;
      r_t      <= '0;
      r_cnt    <= '0;
      in_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_din    <= '0;
      b_din    <= '0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      r_full   <= 1'b0;
`endif
    end else begin
      if (w_acc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      if (w_acc && w_last && r_state != S_LOAD) r_full <= 1'b1;
`endif
      case (r_state)
        S_LOAD: begin
          if (w_acc && w_last) begin
            r_state  <= S_FEED;
            r_t      <= '0;
            in_valid <= 1'b1;
            busy     <= 1'b1;
            a_din    <= w_a_nxt;
            b_din    <= w_b_nxt;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
`endif
          end
        end
        S_FEED: begin
          if (r_t == TW'(2*N-2)) begin
            r_state  <= S_DONE;
            in_valid <= 1'b0;
            done     <= 1'b1;
            a_din    <= '0;
            b_din    <= '0;
          end else begin
            r_t   <= w_tn;
            a_din <= w_a_nxt;
            b_din <= w_b_nxt;
          end
        end
        S_DONE: begin
          done <= 1'b0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
          // A full shadow bank (possibly completed this very cycle) restarts the feed immediately.
          if (r_full || (w_acc && w_last)) begin
            r_state   <= S_FEED;
            r_t       <= '0;
            in_valid  <= 1'b1;
            a_din     <= w_a_nxt;
            b_din     <= w_b_nxt;
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
            r_full    <= 1'b0;
          end else begin
            r_state <= S_LOAD;
            busy    <= 1'b0;
          end
`else
          r_state <= S_LOAD;
          busy    <= 1'b0;
`endif
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=4, 8-bit): scoreboard of expected injection vectors per feed step.
module tb_systolic_feeder;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TOT = 2*N-1;

  logic                  clk = 1'b0;
  logic                  rst_n, ld_valid, abort;
  logic                  ld_ready, in_valid, busy, done;
  logic signed [N*W-1:0] ld_a_row, ld_b_col, a_din, b_din;

  always #5 clk = ~clk;

  systolic_feeder #(.DIN_WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_a_row(ld_a_row), .ld_b_col(ld_b_col), .abort(abort),
    .a_din(a_din), .b_din(b_din), .in_valid(in_valid), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
  } vec_t;

  vec_t           sb[$];
  int             mA[N][N];
  int             mB[N][N];
  logic [N*W-1:0] obs_a[TOT];
  logic [N*W-1:0] obs_b[TOT];
  int             vectors = 0;
  int             miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void set_pattern(input int p);
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        case (p)
          0:       begin mA[r][k] = (r == k) ? 1 : 0; mB[r][k] = (r == k) ? 1 : 0; end
          1:       begin mA[r][k] = 16*r + k;         mB[r][k] = -(16*r + k); end
          default: begin mA[r][k] = 5*k - 7*r;        mB[r][k] = 100 - 9*r - 11*k; end
        endcase
      end
  endfunction

  function automatic logic [N*W-1:0] rowA(input int r);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(mA[r][k]);
    return v;
  endfunction

  function automatic logic [N*W-1:0] colB(input int c);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(mB[k][c]);
    return v;
  endfunction

  function automatic void push_expected();
    vec_t e;
    for (int t = 0; t < TOT; t++) begin
      e = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          e.a[i*W +: W] = W'(mA[i][t-i]);
          e.b[i*W +: W] = W'(mB[t-i][i]);
        end
      end
      sb.push_back(e);
    end
  endfunction

  task automatic load_rows(input int from);
    for (int r = from; r < N; r++) begin
      ld_valid = 1'b1;
      ld_a_row = rowA(r);
      ld_b_col = colB(r);
      step();
    end
    ld_valid = 1'b0;
    push_expected();
  endtask

  // Entered in the first feed cycle; leaves in the LOAD cycle following done.
  task automatic drain_check(input string nm);
    vec_t e;
    int   n = 0;
    while (sb.size() > 0 && n < 4*TOT) begin
      e = sb.pop_front();
      if (n < TOT) begin obs_a[n] = a_din; obs_b[n] = b_din; end
      vectors++;
      if (in_valid !== 1'b1 || a_din !== e.a || b_din !== e.b) begin
        miscompares++;
        $display("FAIL %s step %0d: in_valid=%b a_din=%h b_din=%h, required in_valid=1 a_din=%h b_din=%h",
                 nm, n, in_valid, a_din, b_din, e.a, e.b);
      end
`ifndef SYSTOLIC_FEEDER_DBUF_EN
      vectors++;
      if (ld_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ld_ready in feed step %0d: got %b, required 0", nm, n, ld_ready);
      end
`endif
      step();
      n++;
    end
    vectors++;
    if (in_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done cycle: in_valid=%b done=%b busy=%b, required 0/1/1", nm, in_valid, done, busy);
    end
    step();
    vectors++;
    if (ld_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s return to load: ld_ready=%b done=%b busy=%b, required 1/0/0", nm, ld_ready, done, busy);
    end
  endtask

  task automatic check_idle(input string nm);
    vectors++;
    if (ld_ready !== 1'b1 || in_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        a_din !== '0 || b_din !== '0) begin
      miscompares++;
      $display("FAIL %s: ld_ready=%b in_valid=%b busy=%b done=%b a_din=%h b_din=%h, required 1/0/0/0/0/0",
               nm, ld_ready, in_valid, busy, done, a_din, b_din);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; abort = 1'b0; ld_a_row = '0; ld_b_col = '0;
    step();
    step();
    check_idle("reset_values");
    rst_n = 1'b1;
    step();
    check_idle("after_release");
  endtask

  task automatic test_identity();
    logic [N*W-1:0] x;
    set_pattern(0);
    load_rows(0);
    drain_check("identity");
    x = 32'h0000_0001;
    vectors++;
    if (obs_a[0] !== x) begin miscompares++; $display("FAIL ident_a_t0: got %h, required %h", obs_a[0], x); end
    x = 32'h0000_0100;
    vectors++;
    if (obs_a[2] !== x) begin miscompares++; $display("FAIL ident_a_t2: got %h, required %h", obs_a[2], x); end
    vectors++;
    if (obs_a[3] !== '0) begin miscompares++; $display("FAIL ident_a_t3: got %h, required 0", obs_a[3]); end
  endtask

  task automatic test_signed();
    logic signed [W-1:0] x;
    set_pattern(1);
    load_rows(0);
    drain_check("signed");
    x = obs_a[6][3*W +: W];
    vectors++;
    if (x !== 8'sd51) begin miscompares++; $display("FAIL signed_a3_t6: got %0d, required 51", x); end
    x = obs_b[2][2*W +: W];
    vectors++;
    if (x !== -8'sd2) begin miscompares++; $display("FAIL signed_b2_t2: got %0d, required -2", x); end
  endtask

  task automatic test_hold_valid();
    set_pattern(1);
    load_rows(0);
    set_pattern(2);
    ld_valid = 1'b1;
    ld_a_row = rowA(0);
    ld_b_col = colB(0);
    drain_check("hold_first");
    step();
    load_rows(1);
    drain_check("hold_second");
  endtask

  task automatic test_abort();
    set_pattern(2);
    for (int r = 0; r < 3; r++) begin
      ld_valid = 1'b1; ld_a_row = rowA(r); ld_b_col = colB(r);
      abort = (r == 2);
      step();
    end
    abort = 1'b0; ld_valid = 1'b0;
    check_idle("abort_in_load");
    set_pattern(1);
    load_rows(0);
    drain_check("after_load_abort");
    set_pattern(0);
    load_rows(0);
    for (int s = 0; s < 4; s++) begin
      vec_t e = sb.pop_front();
      vectors++;
      if (in_valid !== 1'b1 || a_din !== e.a || b_din !== e.b) begin
        miscompares++;
        $display("FAIL pre_abort step %0d: a_din=%h b_din=%h, required %h %h", s, a_din, b_din, e.a, e.b);
      end
      if (s < 3) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    sb.delete();
    check_idle("abort_in_feed");
    step();
    check_idle("no_done_after_abort");
    set_pattern(2);
    load_rows(0);
    drain_check("after_feed_abort");
  endtask

  task automatic test_reset_midfeed();
    set_pattern(1);
    load_rows(0);
    for (int s = 0; s < 4; s++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset_midfeed");
    rst_n = 1'b1;
    sb.delete();
    step();
    check_idle("after_midfeed_reset");
    set_pattern(0);
    load_rows(0);
    drain_check("after_reset_reload");
  endtask

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  task automatic test_dbuf();
    vec_t e;
    set_pattern(1);
    load_rows(0);
    set_pattern(2);
    push_expected();
    for (int k = 0; k < 2*TOT+2; k++) begin
      if (k < N) begin ld_valid = 1'b1; ld_a_row = rowA(k); ld_b_col = colB(k); end
      else ld_valid = 1'b0;
      vectors++;
      if (k == TOT || k == 2*TOT+1) begin
        if (in_valid !== 1'b0 || done !== 1'b1) begin
          miscompares++;
          $display("FAIL dbuf gap cycle %0d: in_valid=%b done=%b, required 0/1", k, in_valid, done);
        end
      end else begin
        e = sb.pop_front();
        if (in_valid !== 1'b1 || a_din !== e.a || b_din !== e.b) begin
          miscompares++;
          $display("FAIL dbuf cycle %0d: in_valid=%b a_din=%h b_din=%h, required 1 %h %h",
                   k, in_valid, a_din, b_din, e.a, e.b);
        end
      end
      step();
    end
    check_idle("dbuf_end");
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_signed();
`ifndef SYSTOLIC_FEEDER_DBUF_EN
    test_hold_valid();
`endif
    test_abort();
    test_reset_midfeed();
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    test_dbuf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
